// File: rtl/instr_aligner_pkg.sv
// Shared definitions for the fetch-side instruction aligner: widths, reset PC and bus payloads.
package instr_aligner_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BUF_HW = 4;
  localparam int unsigned HW_W   = 16;
  localparam int unsigned CNT_W  = $clog2(BUF_HW) + 1;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic        word_valid;
    logic [31:0] word;
  } type_fetch2align_s;

  typedef struct packed {
    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic            is_c;
  } type_align2if_s;

endpackage

// File: rtl/instr_aligner_if.sv
// Fetch-word, redirect and instruction handshake bundle between the fetch path and the aligner.
interface instr_aligner_if;
  import instr_aligner_pkg::*;

  logic            flush;
  logic [XLEN-1:0] flush_pc;
  logic [XLEN-1:0] req_pc;
  logic            word_valid;
  logic [31:0]     word;
  logic            word_ready;
  logic            instr_valid;
  logic [31:0]     instr;
  logic [XLEN-1:0] instr_pc;
  logic            is_c;
  logic            instr_ready;

  modport master (
    output flush, flush_pc, word_valid, word, instr_ready,
    input  req_pc, word_ready, instr_valid, instr, instr_pc, is_c
  );

  modport slave (
    input  flush, flush_pc, word_valid, word, instr_ready,
    output req_pc, word_ready, instr_valid, instr, instr_pc, is_c
  );

endinterface

// File: rtl/instr_aligner_hw_ring_buf.sv
// Halfword ring buffer: pushes and pops up to two halfwords per cycle, peeks the two head slots.
module instr_aligner_hw_ring_buf
  import instr_aligner_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [1:0]       push_cnt,
  input  logic [HW_W-1:0]  push_hw0,
  input  logic [HW_W-1:0]  push_hw1,
  input  logic [1:0]       pop_cnt,
  output logic [HW_W-1:0]  hw0,
  output logic [HW_W-1:0]  hw1,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(BUF_HW);

  logic [HW_W-1:0]  mem_q [BUF_HW];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] count_q;

  // Clear wins over any push/pop issued in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(BUF_HW); i++) mem_q[i] <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else if (clear) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_cnt != 2'd0) mem_q[wr_q] <= push_hw0;
      if (push_cnt == 2'd2) mem_q[wr_q + PTR_W'(1)] <= push_hw1;
      wr_q    <= wr_q + PTR_W'(push_cnt);
      rd_q    <= rd_q + PTR_W'(pop_cnt);
      count_q <= count_q + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
    end
  end

  assign hw0   = mem_q[rd_q];
  assign hw1   = mem_q[rd_q + PTR_W'(1)];
  assign count = count_q;

endmodule

// File: rtl/instr_aligner.sv
// Fetch-side aligner: buffers 32-bit fetch words as halfwords and issues one RV32/RVC instruction per handshake.
module instr_aligner
  import instr_aligner_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  instr_aligner_if.slave bus
);

  typedef enum logic {ALN_RUN, ALN_SKIP_LO} type_aln_state_e;

  type_aln_state_e   state_q;
  type_aln_state_e   state_nxt;
  logic              skip_lo_c;

  type_fetch2align_s fetch;
  type_align2if_s    head;

  logic [HW_W-1:0]   hw0;
  logic [HW_W-1:0]   hw1;
  logic [CNT_W-1:0]  count;
  logic [XLEN-1:0]   req_pc_q;
  logic [XLEN-1:0]   pc_q;
  logic [31:0]       last_instr_q;
  logic              last_is_c_q;

  logic              word_ready_c;
  logic              accept_c;
  logic              pop_c;
  logic [1:0]        push_cnt;
  logic [1:0]        pop_cnt;
  logic [HW_W-1:0]   push_hw0;

  assign fetch = {bus.word_valid, bus.word};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ALN_RUN;
    else        state_q <= state_nxt;
  end

  // A redirect to an odd-halfword PC must discard the low half of its first fetch word
  always_comb begin
    state_nxt = state_q;
    if (bus.flush)
      state_nxt = bus.flush_pc[1] ? ALN_SKIP_LO : ALN_RUN;
    else if (accept_c && state_q == ALN_SKIP_LO)
      state_nxt = ALN_RUN;
  end

  always_comb begin
    skip_lo_c = 1'b0;
    if (state_q == ALN_SKIP_LO) skip_lo_c = 1'b1;
  end

  // Head decode: RVC if the low two bits are not 2'b11
  always_comb begin
    head             = '0;
    head.is_c        = (hw0[1:0] != 2'b11);
    head.instr       = head.is_c ? {16'h0000, hw0} : {hw1, hw0};
    head.instr_pc    = pc_q;
    head.instr_valid = (head.is_c ? (count >= CNT_W'(1)) : (count >= CNT_W'(2))) & ~bus.flush;
  end

  assign word_ready_c = (count <= CNT_W'(BUF_HW - 2)) & ~bus.flush;
  assign accept_c     = fetch.word_valid & word_ready_c;
  assign pop_c        = head.instr_valid & bus.instr_ready;

  always_comb begin
    push_cnt = 2'd0;
    pop_cnt  = 2'd0;
    push_hw0 = skip_lo_c ? fetch.word[31:16] : fetch.word[15:0];
    if (accept_c) push_cnt = skip_lo_c ? 2'd1 : 2'd2;
    if (pop_c)    pop_cnt  = head.is_c ? 2'd1 : 2'd2;
  end

  instr_aligner_hw_ring_buf u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (bus.flush),
    .push_cnt (push_cnt),
    .push_hw0 (push_hw0),
    .push_hw1 (fetch.word[31:16]),
    .pop_cnt  (pop_cnt),
    .hw0      (hw0),
    .hw1      (hw1),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc_q <= RESET_PC;
      pc_q     <= RESET_PC;
    end else if (bus.flush) begin
      req_pc_q <= {bus.flush_pc[XLEN-1:2], 2'b00};
      pc_q     <= bus.flush_pc;
    end else begin
      if (accept_c) req_pc_q <= req_pc_q + XLEN'(4);
      if (pop_c)    pc_q     <= pc_q + (head.is_c ? XLEN'(2) : XLEN'(4));
    end
  end

  // Remember the last issued-view instruction so the output holds while the head is incomplete
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_instr_q <= '0;
      last_is_c_q  <= 1'b0;
    end else if (head.instr_valid) begin
      last_instr_q <= head.instr;
      last_is_c_q  <= head.is_c;
    end
  end

  assign bus.req_pc      = req_pc_q;
  assign bus.word_ready  = word_ready_c;
  assign bus.instr_valid = head.instr_valid;
  assign bus.instr       = head.instr_valid ? head.instr : last_instr_q;
  assign bus.is_c        = head.instr_valid ? head.is_c  : last_is_c_q;
  assign bus.instr_pc    = head.instr_pc;

endmodule

// File: tb/tb_instr_aligner.sv
// Bench for instr_aligner: directed scenarios plus randomized fetch/consume/redirect traffic vs a PC-walking model.
module tb_instr_aligner;
  import instr_aligner_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_aligner_if bus();

  instr_aligner dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  logic [31:0] seed;
  logic [31:0] pc_m;
  logic [31:0] req_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Synthetic memory image: any word address maps to a pseudo-random word
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] x;
    x = (a ^ seed) * 32'h9E37_79B1;
    x = x ^ (x >> 15);
    return x;
  endfunction

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem_word({pc[31:2], 2'b00});
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  task automatic flush_to(input logic [31:0] pc);
    bus.flush    = 1'b1;
    bus.flush_pc = pc;
    bus.word_valid = 1'b0;
    tick();
    bus.flush = 1'b0;
    pc_m  = pc;
    req_m = {pc[31:2], 2'b00};
  endtask

  // Random traffic; expectations come from fetched-ahead distance and the instruction stream at pc_m
  task automatic run(input int n, input int rdy_pct, input int flush_pct, input int wv_pct);
    for (int i = 0; i < n; i++) begin
      logic        fl;
      logic [31:0] r;
      logic [31:0] fpc;
      logic [15:0] h0;
      logic [15:0] h1;
      logic        isc;
      int          avail;
      logic        ev;
      logic        er;
      r   = $urandom;
      fpc = {r[31:1], 1'b0};
      fl  = ($urandom_range(0, 99) < flush_pct);
      bus.flush       = fl;
      bus.flush_pc    = fpc;
      bus.word_valid  = ($urandom_range(0, 99) < wv_pct);
      bus.word        = mem_word(req_m);
      bus.instr_ready = ($urandom_range(0, 99) < rdy_pct);
      #1;
      h0    = hw_at(pc_m);
      h1    = hw_at(pc_m + 32'd2);
      isc   = (h0[1:0] != 2'b11);
      avail = int'($signed(req_m - pc_m)) / 2;
      ev    = !fl && (avail >= (isc ? 1 : 2));
      er    = !fl && (avail <= int'(BUF_HW) - 2);
      chk("req_pc", bus.req_pc, req_m);
      chk("instr_pc", bus.instr_pc, pc_m);
      chk("word_ready", 32'(bus.word_ready), 32'(er));
      chk("instr_valid", 32'(bus.instr_valid), 32'(ev));
      if (ev) begin
        chk("instr", bus.instr, isc ? {16'h0000, h0} : {h1, h0});
        chk("is_c", 32'(bus.is_c), 32'(isc));
      end
      @(posedge clk);
      if (fl) begin
        pc_m  = fpc;
        req_m = {fpc[31:2], 2'b00};
      end else begin
        if (bus.word_valid && er) req_m = req_m + 32'd4;
        if (ev && bus.instr_ready) pc_m = pc_m + (isc ? 32'd2 : 32'd4);
      end
      #1;
    end
    bus.flush      = 1'b0;
    bus.word_valid = 1'b0;
    bus.instr_ready = 1'b0;
  endtask

  initial begin
    bus.flush = 1'b0; bus.flush_pc = '0; bus.word_valid = 1'b0; bus.word = '0; bus.instr_ready = 1'b0;
    seed = $urandom;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_req_pc", bus.req_pc, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, 32'h0);
    chk("rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_is_c", 32'(bus.is_c), 32'h0);
    chk("rst_word_ready", 32'(bus.word_ready), 32'h1);

    // 32-bit addi at PC 0, valid the cycle after acceptance
    bus.word_valid = 1'b1; bus.word = 32'h00A0_0513;
    tick(); bus.word_valid = 1'b0; #1;
    chk("t1_valid", 32'(bus.instr_valid), 32'h1);
    chk("t1_instr", bus.instr, 32'h00A0_0513);
    chk("t1_is_c", 32'(bus.is_c), 32'h0);
    chk("t1_pc", bus.instr_pc, 32'h0);
    chk("t1_req_pc", bus.req_pc, 32'h4);
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0; #1;
    chk("t1_empty", 32'(bus.instr_valid), 32'h0);
    chk("t1_hold", bus.instr, 32'h00A0_0513);
    chk("t1_pc_adv", bus.instr_pc, 32'h4);

    // Two c.li in one word
    flush_to(32'h0);
    bus.word_valid = 1'b1; bus.word = 32'h4505_4501;
    tick(); bus.word_valid = 1'b0; #1;
    chk("t2_i0", bus.instr, 32'h0000_4501);
    chk("t2_c0", 32'(bus.is_c), 32'h1);
    chk("t2_pc0", bus.instr_pc, 32'h0);
    bus.instr_ready = 1'b1; tick(); #1;
    chk("t2_v1", 32'(bus.instr_valid), 32'h1);
    chk("t2_i1", bus.instr, 32'h0000_4505);
    chk("t2_pc1", bus.instr_pc, 32'h2);
    tick(); #1;
    chk("t2_empty", 32'(bus.instr_valid), 32'h0);
    chk("t2_pc2", bus.instr_pc, 32'h4);

    // 32-bit instruction split across two words
    flush_to(32'h0);
    bus.word_valid = 1'b1; bus.word = 32'h0513_4501;
    tick(); bus.word_valid = 1'b0; #1;
    chk("t3_c", bus.instr, 32'h0000_4501);
    chk("t3_c_pc", bus.instr_pc, 32'h0);
    tick(); #1;
    chk("t3_partial", 32'(bus.instr_valid), 32'h0);
    chk("t3_partial_pc", bus.instr_pc, 32'h2);
    bus.word_valid = 1'b1; bus.word = 32'h4585_00A0;
    tick(); bus.word_valid = 1'b0; #1;
    chk("t3_v32", 32'(bus.instr_valid), 32'h1);
    chk("t3_i32", bus.instr, 32'h00A0_0513);
    chk("t3_c32", 32'(bus.is_c), 32'h0);
    chk("t3_pc32", bus.instr_pc, 32'h2);
    tick(); #1;
    chk("t3_next", bus.instr, 32'h0000_4585);
    chk("t3_next_pc", bus.instr_pc, 32'h6);
    bus.instr_ready = 1'b0;

    // Flush to odd halfword with a full buffer and a stalled consumer
    flush_to(32'h0);
    bus.word_valid = 1'b1; bus.word = 32'h4501_4501;
    tick(); tick(); #1;
    chk("t4_full", 32'(bus.word_ready), 32'h0);
    bus.flush = 1'b1; bus.flush_pc = 32'h102; bus.word = 32'hDEAD_BEEF; #1;
    chk("t4_flush_valid", 32'(bus.instr_valid), 32'h0);
    tick(); bus.flush = 1'b0; bus.word_valid = 1'b0; #1;
    chk("t4_req_pc", bus.req_pc, 32'h100);
    chk("t4_pc", bus.instr_pc, 32'h102);
    chk("t4_empty", 32'(bus.instr_valid), 32'h0);
    chk("t4_ready", 32'(bus.word_ready), 32'h1);
    bus.word_valid = 1'b1; bus.word = 32'h4585_1234;
    tick(); bus.word_valid = 1'b0; #1;
    chk("t4_instr", bus.instr, 32'h0000_4585);
    chk("t4_is_c", 32'(bus.is_c), 32'h1);
    chk("t4_ipc", bus.instr_pc, 32'h102);
    bus.instr_ready = 1'b1; tick(); bus.instr_ready = 1'b0; #1;
    chk("t4_only_one", 32'(bus.instr_valid), 32'h0);
    chk("t4_pc_adv", bus.instr_pc, 32'h104);

    // Long stall with continuous fetch, then drain
    flush_to(32'h200);
    run(10, 0, 0, 100);
    bus.word_valid = 1'b1; #1;
    chk("t5_full", 32'(bus.word_ready), 32'h0);
    bus.word_valid = 1'b0;
    run(40, 100, 0, 100);

    // Fetch address wrap
    flush_to(32'hFFFF_FFFC);
    run(1, 0, 0, 100);
    chk("t6_wrap", bus.req_pc, 32'h0);
    run(30, 70, 0, 80);

    // Mixed random traffic with redirects, mid-run reset, more traffic
    flush_to(32'h1000);
    run(2000, 60, 5, 75);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.instr_valid), 32'h0);
    chk("mid_rst_req_pc", bus.req_pc, 32'h0);
    chk("mid_rst_pc", bus.instr_pc, 32'h0);
    chk("mid_rst_instr", bus.instr, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    pc_m = 32'h0; req_m = 32'h0;
    #1;
    run(1000, 80, 5, 75);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
